// File: rtl/getir_denetleyici.sv
// Fetch-stage controller: owns the PS, issues one outstanding word read at a time
// and feeds a single-entry buffer (tampon) to the compressed-instruction realignment queue.
module getir_denetleyici #(
  parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ps_atla_i,
  input  logic [31:0] yeni_ps_i,
  input  logic        coz_durdur_i,
  input  logic        kuyruk_ps_durdur_i,
  output logic        bellek_istek_o,
  output logic [31:0] bellek_adres_o,
  input  logic        bellek_istek_hazir_i,
  input  logic        bellek_yanit_gecerli_i,
  input  logic [31:0] bellek_yanit_i,
  output logic [31:0] kuyruk_buyruk_o,
  output logic        kuyruk_aktif_o,
  output logic        kuyruk_ps_atladi_o,
  output logic [31:0] ps_o
);

  typedef enum logic [1:0] {
    ISTE  = 2'd0,
    BEKLE = 2'd1,
    DOLU  = 2'd2
  } durum_t;

  durum_t      durum_r;
  logic [31:0] ps_r;
  logic [31:0] adres_r;
  logic [31:0] tampon_r;
  logic [31:0] tampon_ps_r;
  logic        tampon_gecerli_r;
  logic        iptal_r;
  logic        bosalt_r;
  logic        atladi_r;

  logic [31:0] hedef_ps;
  logic        aktif;
  logic        tuket;
  logic        istek;
  logic        kabul;
  logic [31:0] adres;

  // A request is only raised when its response is guaranteed a free tampon; a stale
  // request (iptal_r in ISTE) must stay up at its original address until accepted.
  always_comb begin
    hedef_ps = yeni_ps_i & ~32'd3;
    aktif    = !coz_durdur_i && (tampon_gecerli_r || bosalt_r);
    tuket    = aktif && tampon_gecerli_r && !bosalt_r;
    istek    = (durum_r == ISTE) && (iptal_r || !tampon_gecerli_r || tuket);
    kabul    = istek && bellek_istek_hazir_i;
    adres    = ((durum_r == ISTE) && iptal_r) ? adres_r : ps_r;

    bellek_istek_o     = !rst_i && istek;
    bellek_adres_o     = rst_i ? '0 : adres;
    kuyruk_aktif_o     = !rst_i && aktif;
    kuyruk_ps_atladi_o = !rst_i && atladi_r && tampon_gecerli_r;
    kuyruk_buyruk_o    = (!rst_i && tampon_gecerli_r) ? tampon_r : '0;
    ps_o               = (!rst_i && tampon_gecerli_r) ? tampon_ps_r : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_r          <= ISTE;
      ps_r             <= BASLANGIC_PS & ~32'd3;
      adres_r          <= '0;
      tampon_r         <= '0;
      tampon_ps_r      <= '0;
      tampon_gecerli_r <= 1'b0;
      iptal_r          <= 1'b0;
      bosalt_r         <= 1'b0;
      atladi_r         <= 1'b1;
    end else begin
      if (aktif) begin
        bosalt_r <= kuyruk_ps_durdur_i;
      end
      if (tuket) begin
        tampon_gecerli_r <= 1'b0;
        atladi_r         <= 1'b0;
      end

      case (durum_r)
        ISTE: begin
          if (kabul) begin
            adres_r <= adres;
            durum_r <= BEKLE;
            if (!iptal_r) begin
              ps_r <= ps_r + 32'd4;
            end
          end else if (!istek) begin
            durum_r <= DOLU;
          end
        end
        BEKLE: begin
          if (bellek_yanit_gecerli_i) begin
            durum_r <= ISTE;
            if (iptal_r) begin
              iptal_r <= 1'b0;
            end else begin
              tampon_r         <= bellek_yanit_i;
              tampon_ps_r      <= adres_r;
              tampon_gecerli_r <= 1'b1;
              if (tampon_gecerli_r && !tuket) begin
                durum_r <= DOLU;
              end
            end
          end
        end
        DOLU: begin
          if (tuket) begin
            durum_r <= ISTE;
          end
        end
        default: durum_r <= ISTE;
      endcase

      // Redirect overrides every update above; an in-flight or not-yet-accepted
      // request is kept on the bus but its response is marked for discard.
      if (ps_atla_i) begin
        ps_r             <= hedef_ps;
        tampon_gecerli_r <= 1'b0;
        bosalt_r         <= 1'b0;
        atladi_r         <= 1'b1;
        case (durum_r)
          ISTE: begin
            if (istek) begin
              iptal_r <= 1'b1;
              adres_r <= adres;
            end else begin
              durum_r <= ISTE;
            end
          end
          BEKLE: begin
            if (bellek_yanit_gecerli_i) begin
              iptal_r <= 1'b0;
              durum_r <= ISTE;
            end else begin
              iptal_r <= 1'b1;
            end
          end
          default: durum_r <= ISTE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_getir_denetleyici.sv
// Directed bench for getir_denetleyici with a small instruction-memory responder
// whose acceptance latency and forced data are set per scenario.
module tb_getir_denetleyici;

  logic        clk;
  logic        rst;
  logic        ps_atla;
  logic [31:0] yeni_ps;
  logic        coz_durdur;
  logic        kuyruk_durdur;
  logic        bellek_istek;
  logic [31:0] bellek_adres;
  logic        hazir;
  logic        yanit_gecerli;
  logic [31:0] yanit;
  logic [31:0] kuyruk_buyruk;
  logic        kuyruk_aktif;
  logic        kuyruk_atladi;
  logic [31:0] ps;

  int          sayim;
  int          hata;
  int          gecikme;
  logic        zorla;
  logic        temizle;
  logic        bekleyen;
  int          sayac;
  logic [31:0] bekleyen_veri;

  getir_denetleyici #(.BASLANGIC_PS(32'h4000_0000)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .ps_atla_i              (ps_atla),
    .yeni_ps_i              (yeni_ps),
    .coz_durdur_i           (coz_durdur),
    .kuyruk_ps_durdur_i     (kuyruk_durdur),
    .bellek_istek_o         (bellek_istek),
    .bellek_adres_o         (bellek_adres),
    .bellek_istek_hazir_i   (hazir),
    .bellek_yanit_gecerli_i (yanit_gecerli),
    .bellek_yanit_i         (yanit),
    .kuyruk_buyruk_o        (kuyruk_buyruk),
    .kuyruk_aktif_o         (kuyruk_aktif),
    .kuyruk_ps_atladi_o     (kuyruk_atladi),
    .ps_o                   (ps)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] bellek_oku(input logic [31:0] a);
    case (a)
      32'h4000_0000: bellek_oku = 32'h0000_0013;
      32'h4000_0004: bellek_oku = 32'h0010_0093;
      32'h4000_0200: bellek_oku = 32'h4501_4501;
      32'h4000_0204: bellek_oku = 32'h00A0_0513;
      default:       bellek_oku = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // Memory responder: acts 3 time units after each rising edge, after the main
  // process has driven and checked, so request/ready seen here are final.
  initial begin
    yanit_gecerli = 1'b0;
    yanit         = '0;
    bekleyen      = 1'b0;
    sayac         = 0;
    bekleyen_veri = '0;
    forever begin
      @(posedge clk);
      #3;
      yanit_gecerli = 1'b0;
      if (temizle) begin
        bekleyen = 1'b0;
      end else if (bekleyen) begin
        if (sayac == 0) begin
          yanit_gecerli = 1'b1;
          yanit         = bekleyen_veri;
          bekleyen      = 1'b0;
        end else begin
          sayac = sayac - 1;
        end
      end
      if (bellek_istek && hazir) begin
        bekleyen      = 1'b1;
        sayac         = gecikme - 1;
        bekleyen_veri = zorla ? 32'hDEAD_BEEF : bellek_oku(bellek_adres);
      end
    end
  end

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  task automatic sifirla();
    adim();
    rst = 1'b1; temizle = 1'b1; ps_atla = 1'b0; yeni_ps = '0;
    coz_durdur = 1'b0; kuyruk_durdur = 1'b0; hazir = 1'b1; zorla = 1'b0; gecikme = 1;
    adim();
    adim();
    rst = 1'b0; temizle = 1'b0;
  endtask

  task automatic test_reset();
    adim();
    rst = 1'b1; temizle = 1'b1; hazir = 1'b1;
    #1;
    sayim++; if (bellek_istek !== 1'b0) begin hata++; $display("FAIL reset_istek: got %b want 0", bellek_istek); end
    sayim++; if (bellek_adres !== 32'h0) begin hata++; $display("FAIL reset_adres: got %h want 00000000", bellek_adres); end
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL reset_aktif: got %b want 0", kuyruk_aktif); end
    sayim++; if (kuyruk_buyruk !== 32'h0) begin hata++; $display("FAIL reset_buyruk: got %h want 00000000", kuyruk_buyruk); end
    sayim++; if (kuyruk_atladi !== 1'b0) begin hata++; $display("FAIL reset_atladi: got %b want 0", kuyruk_atladi); end
    sayim++; if (ps !== 32'h0) begin hata++; $display("FAIL reset_ps: got %h want 00000000", ps); end
    adim();
    adim();
    rst = 1'b0; temizle = 1'b0;
    #1;
    sayim++; if (bellek_istek !== 1'b1) begin hata++; $display("FAIL reset_ilk_istek: got %b want 1", bellek_istek); end
    sayim++; if (bellek_adres !== 32'h4000_0000) begin hata++; $display("FAIL reset_ilk_adres: got %h want 40000000", bellek_adres); end
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL reset_ilk_aktif: got %b want 0", kuyruk_aktif); end
  endtask

  task automatic test_temel();
    sifirla();
    #1;
    sayim++; if (bellek_adres !== 32'h4000_0000) begin hata++; $display("FAIL temel_adres0: got %h want 40000000", bellek_adres); end
    adim(); #1;
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL temel_bekle_aktif: got %b want 0", kuyruk_aktif); end
    sayim++; if (bellek_istek !== 1'b0) begin hata++; $display("FAIL temel_bekle_istek: got %b want 0", bellek_istek); end
    adim(); #1;
    sayim++; if (kuyruk_aktif !== 1'b1) begin hata++; $display("FAIL temel_aktif1: got %b want 1", kuyruk_aktif); end
    sayim++; if (kuyruk_buyruk !== 32'h0000_0013) begin hata++; $display("FAIL temel_buyruk1: got %h want 00000013", kuyruk_buyruk); end
    sayim++; if (ps !== 32'h4000_0000) begin hata++; $display("FAIL temel_ps1: got %h want 40000000", ps); end
    sayim++; if (kuyruk_atladi !== 1'b1) begin hata++; $display("FAIL temel_atladi1: got %b want 1", kuyruk_atladi); end
    sayim++; if (bellek_adres !== 32'h4000_0004) begin hata++; $display("FAIL temel_adres1: got %h want 40000004", bellek_adres); end
    adim(); #1;
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL temel_bos_aktif: got %b want 0", kuyruk_aktif); end
    adim(); #1;
    sayim++; if (kuyruk_buyruk !== 32'h0010_0093) begin hata++; $display("FAIL temel_buyruk2: got %h want 00100093", kuyruk_buyruk); end
    sayim++; if (ps !== 32'h4000_0004) begin hata++; $display("FAIL temel_ps2: got %h want 40000004", ps); end
    sayim++; if (kuyruk_atladi !== 1'b0) begin hata++; $display("FAIL temel_atladi2: got %b want 0", kuyruk_atladi); end
  endtask

  task automatic test_coz_durdur();
    sifirla();
    adim();
    adim();
    coz_durdur = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) adim();
      #1;
      sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL coz_aktif[%0d]: got %b want 0", i, kuyruk_aktif); end
      sayim++; if (bellek_istek !== 1'b0) begin hata++; $display("FAIL coz_istek[%0d]: got %b want 0", i, bellek_istek); end
      sayim++; if (kuyruk_buyruk !== 32'h0000_0013) begin hata++; $display("FAIL coz_buyruk[%0d]: got %h want 00000013", i, kuyruk_buyruk); end
      sayim++; if (ps !== 32'h4000_0000) begin hata++; $display("FAIL coz_ps[%0d]: got %h want 40000000", i, ps); end
    end
    adim();
    coz_durdur = 1'b0;
    #1;
    sayim++; if (kuyruk_aktif !== 1'b1) begin hata++; $display("FAIL coz_birak_aktif: got %b want 1", kuyruk_aktif); end
    sayim++; if (kuyruk_buyruk !== 32'h0000_0013) begin hata++; $display("FAIL coz_birak_buyruk: got %h want 00000013", kuyruk_buyruk); end
    sayim++; if (kuyruk_atladi !== 1'b1) begin hata++; $display("FAIL coz_birak_atladi: got %b want 1", kuyruk_atladi); end
    sayim++; if (bellek_istek !== 1'b0) begin hata++; $display("FAIL coz_dolu_istek: got %b want 0", bellek_istek); end
    adim(); #1;
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL coz_tekrar_yok: got %b want 0", kuyruk_aktif); end
    sayim++; if (bellek_adres !== 32'h4000_0004) begin hata++; $display("FAIL coz_sonraki_adres: got %h want 40000004", bellek_adres); end
    adim();
    adim(); #1;
    sayim++; if (kuyruk_buyruk !== 32'h0010_0093) begin hata++; $display("FAIL coz_sonraki_buyruk: got %h want 00100093", kuyruk_buyruk); end
    sayim++; if (ps !== 32'h4000_0004) begin hata++; $display("FAIL coz_sonraki_ps: got %h want 40000004", ps); end
  endtask

  task automatic test_bosalt();
    sifirla();
    ps_atla = 1'b1; yeni_ps = 32'h4000_0200;
    #1;
    sayim++; if (bellek_adres !== 32'h4000_0000) begin hata++; $display("FAIL bosalt_eski_adres: got %h want 40000000", bellek_adres); end
    adim(); ps_atla = 1'b0; #1;
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL bosalt_iptal_aktif: got %b want 0", kuyruk_aktif); end
    adim(); #1;
    sayim++; if (bellek_adres !== 32'h4000_0200) begin hata++; $display("FAIL bosalt_hedef_adres: got %h want 40000200", bellek_adres); end
    adim();
    adim(); kuyruk_durdur = 1'b1; #1;
    sayim++; if (kuyruk_buyruk !== 32'h4501_4501) begin hata++; $display("FAIL bosalt_buyruk0: got %h want 45014501", kuyruk_buyruk); end
    sayim++; if (ps !== 32'h4000_0200) begin hata++; $display("FAIL bosalt_ps0: got %h want 40000200", ps); end
    sayim++; if (kuyruk_atladi !== 1'b1) begin hata++; $display("FAIL bosalt_atladi0: got %b want 1", kuyruk_atladi); end
    adim(); kuyruk_durdur = 1'b0; coz_durdur = 1'b1; #1;
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL bosalt_coz_aktif: got %b want 0", kuyruk_aktif); end
    adim(); coz_durdur = 1'b0; #1;
    sayim++; if (kuyruk_aktif !== 1'b1) begin hata++; $display("FAIL bosalt_drain_aktif: got %b want 1", kuyruk_aktif); end
    sayim++; if (ps !== 32'h4000_0204) begin hata++; $display("FAIL bosalt_drain_ps: got %h want 40000204", ps); end
    sayim++; if (kuyruk_buyruk !== 32'h00A0_0513) begin hata++; $display("FAIL bosalt_drain_buyruk: got %h want 00a00513", kuyruk_buyruk); end
    sayim++; if (bellek_istek !== 1'b0) begin hata++; $display("FAIL bosalt_drain_istek: got %b want 0", bellek_istek); end
    adim(); #1;
    sayim++; if (kuyruk_aktif !== 1'b1) begin hata++; $display("FAIL bosalt_tuket_aktif: got %b want 1", kuyruk_aktif); end
    sayim++; if (ps !== 32'h4000_0204) begin hata++; $display("FAIL bosalt_tuket_ps: got %h want 40000204", ps); end
    sayim++; if (kuyruk_atladi !== 1'b0) begin hata++; $display("FAIL bosalt_tuket_atladi: got %b want 0", kuyruk_atladi); end
    adim(); #1;
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL bosalt_sonra_aktif: got %b want 0", kuyruk_aktif); end
    sayim++; if (bellek_adres !== 32'h4000_0208) begin hata++; $display("FAIL bosalt_sonra_adres: got %h want 40000208", bellek_adres); end
  endtask

  task automatic test_atla_bekle();
    sifirla();
    zorla = 1'b1; gecikme = 4;
    #1;
    sayim++; if (bellek_adres !== 32'h4000_0000) begin hata++; $display("FAIL bekle_adres0: got %h want 40000000", bellek_adres); end
    adim(); zorla = 1'b0; ps_atla = 1'b1; yeni_ps = 32'h4000_0102; #1;
    sayim++; if (bellek_istek !== 1'b0) begin hata++; $display("FAIL bekle_istek: got %b want 0", bellek_istek); end
    adim(); ps_atla = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) adim();
      #1;
      sayim++; if (kuyruk_buyruk === 32'hDEAD_BEEF) begin hata++; $display("FAIL bekle_bayat[%0d]: got %h want not deadbeef", i, kuyruk_buyruk); end
      sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL bekle_aktif[%0d]: got %b want 0", i, kuyruk_aktif); end
    end
    adim(); gecikme = 1; #1;
    sayim++; if (bellek_istek !== 1'b1) begin hata++; $display("FAIL bekle_yeni_istek: got %b want 1", bellek_istek); end
    sayim++; if (bellek_adres !== 32'h4000_0100) begin hata++; $display("FAIL bekle_yeni_adres: got %h want 40000100", bellek_adres); end
    adim(); #1;
    sayim++; if (kuyruk_buyruk === 32'hDEAD_BEEF) begin hata++; $display("FAIL bekle_bayat_son: got %h want not deadbeef", kuyruk_buyruk); end
    adim(); #1;
    sayim++; if (kuyruk_buyruk !== 32'hC0DE_0100) begin hata++; $display("FAIL bekle_buyruk: got %h want c0de0100", kuyruk_buyruk); end
    sayim++; if (ps !== 32'h4000_0100) begin hata++; $display("FAIL bekle_ps: got %h want 40000100", ps); end
    sayim++; if (kuyruk_atladi !== 1'b1) begin hata++; $display("FAIL bekle_atladi: got %b want 1", kuyruk_atladi); end
  endtask

  task automatic test_atla_iste();
    sifirla();
    hazir = 1'b0; ps_atla = 1'b1; yeni_ps = 32'h4000_0300;
    #1;
    sayim++; if (bellek_adres !== 32'h4000_0000) begin hata++; $display("FAIL iste_adres0: got %h want 40000000", bellek_adres); end
    adim(); ps_atla = 1'b0; #1;
    sayim++; if (bellek_istek !== 1'b1) begin hata++; $display("FAIL iste_tut_istek: got %b want 1", bellek_istek); end
    sayim++; if (bellek_adres !== 32'h4000_0000) begin hata++; $display("FAIL iste_tut_adres: got %h want 40000000", bellek_adres); end
    adim(); hazir = 1'b1; #1;
    sayim++; if (bellek_adres !== 32'h4000_0000) begin hata++; $display("FAIL iste_kabul_adres: got %h want 40000000", bellek_adres); end
    adim(); #1;
    sayim++; if (bellek_istek !== 1'b0) begin hata++; $display("FAIL iste_bekle_istek: got %b want 0", bellek_istek); end
    adim(); #1;
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL iste_dusur_aktif: got %b want 0", kuyruk_aktif); end
    sayim++; if (bellek_adres !== 32'h4000_0300) begin hata++; $display("FAIL iste_hedef_adres: got %h want 40000300", bellek_adres); end
    adim();
    adim(); #1;
    sayim++; if (kuyruk_buyruk !== 32'hC0DE_0300) begin hata++; $display("FAIL iste_buyruk: got %h want c0de0300", kuyruk_buyruk); end
    sayim++; if (ps !== 32'h4000_0300) begin hata++; $display("FAIL iste_ps: got %h want 40000300", ps); end
    sayim++; if (kuyruk_atladi !== 1'b1) begin hata++; $display("FAIL iste_atladi: got %b want 1", kuyruk_atladi); end
  endtask

  task automatic test_sarma();
    sifirla();
    ps_atla = 1'b1; yeni_ps = 32'hFFFF_FFFF;
    adim(); ps_atla = 1'b0;
    adim(); #1;
    sayim++; if (bellek_adres !== 32'hFFFF_FFFC) begin hata++; $display("FAIL sarma_adres: got %h want fffffffc", bellek_adres); end
    adim();
    adim(); #1;
    sayim++; if (kuyruk_buyruk !== 32'hC0DE_FFFC) begin hata++; $display("FAIL sarma_buyruk: got %h want c0defffc", kuyruk_buyruk); end
    sayim++; if (ps !== 32'hFFFF_FFFC) begin hata++; $display("FAIL sarma_ps: got %h want fffffffc", ps); end
    sayim++; if (bellek_istek !== 1'b1) begin hata++; $display("FAIL sarma_istek: got %b want 1", bellek_istek); end
    sayim++; if (bellek_adres !== 32'h0000_0000) begin hata++; $display("FAIL sarma_adres_sifir: got %h want 00000000", bellek_adres); end
  endtask

  task automatic test_reset_bekle();
    sifirla();
    gecikme = 2;
    adim(); rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) adim();
      #1;
      sayim++; if (bellek_istek !== 1'b0) begin hata++; $display("FAIL rbekle_istek[%0d]: got %b want 0", i, bellek_istek); end
      sayim++; if (bellek_adres !== 32'h0) begin hata++; $display("FAIL rbekle_adres[%0d]: got %h want 00000000", i, bellek_adres); end
      sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL rbekle_aktif[%0d]: got %b want 0", i, kuyruk_aktif); end
      sayim++; if (kuyruk_buyruk !== 32'h0) begin hata++; $display("FAIL rbekle_buyruk[%0d]: got %h want 00000000", i, kuyruk_buyruk); end
      sayim++; if (ps !== 32'h0) begin hata++; $display("FAIL rbekle_ps[%0d]: got %h want 00000000", i, ps); end
    end
    adim(); rst = 1'b0; gecikme = 1; #1;
    sayim++; if (bellek_istek !== 1'b1) begin hata++; $display("FAIL rbekle_ilk_istek: got %b want 1", bellek_istek); end
    sayim++; if (bellek_adres !== 32'h4000_0000) begin hata++; $display("FAIL rbekle_ilk_adres: got %h want 40000000", bellek_adres); end
    sayim++; if (kuyruk_aktif !== 1'b0) begin hata++; $display("FAIL rbekle_ilk_aktif: got %b want 0", kuyruk_aktif); end
    adim();
    adim(); #1;
    sayim++; if (kuyruk_buyruk !== 32'h0000_0013) begin hata++; $display("FAIL rbekle_buyruk: got %h want 00000013", kuyruk_buyruk); end
    sayim++; if (ps !== 32'h4000_0000) begin hata++; $display("FAIL rbekle_ps: got %h want 40000000", ps); end
    sayim++; if (kuyruk_atladi !== 1'b1) begin hata++; $display("FAIL rbekle_atladi: got %b want 1", kuyruk_atladi); end
  endtask

  initial begin
    sayim = 0; hata = 0;
    rst = 1'b1; temizle = 1'b1; ps_atla = 1'b0; yeni_ps = '0;
    coz_durdur = 1'b0; kuyruk_durdur = 1'b0; hazir = 1'b0; zorla = 1'b0; gecikme = 1;
    test_reset();
    test_temel();
    test_coz_durdur();
    test_bosalt();
    test_atla_bekle();
    test_atla_iste();
    test_sarma();
    test_reset_bekle();
    $display("End of test - %0d assertions evaluated, %0d failures", sayim, hata);
    $finish;
  end

endmodule

// File: doc/getir_denetleyici.md
Name: getir_denetleyici

Overview:
- Fetch-stage controller that sequences instruction fetch for the compressed-instruction realignment queue.
- Owns the program counter (PS) and issues word-aligned read requests to instruction memory with a valid/ready handshake.
- Buffers one returned word and feeds it to the queue, driving the queue's enable and redirect flags.
- Honours the queue's hold request, downstream decode stalls and branch redirects, and discards stale responses after a redirect.

Parameters:
- BASLANGIC_PS, 32'h4000_0000, PS value loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- ps_atla_i  in  1  redirect pulse (branch/jump taken).
- yeni_ps_i  in  32  redirect target; bits [1:0] ignored.
- coz_durdur_i  in  1  decode stall; queue must not advance.
- kuyruk_ps_durdur_i  in  1  queue hold request (upper compressed half pending).
- bellek_istek_o  out  1  read request valid.
- bellek_adres_o  out  32  request address, bits [1:0] always 0.
- bellek_istek_hazir_i  in  1  memory accepts request.
- bellek_yanit_gecerli_i  in  1  read data valid; at least 1 cycle after accept.
- bellek_yanit_i  in  32  read data.
- kuyruk_buyruk_o  out  32  word presented to queue.
- kuyruk_aktif_o  out  1  queue enable for this cycle.
- kuyruk_ps_atladi_o  out  1  presented word is first after a redirect.
- ps_o  out  32  word address of kuyruk_buyruk_o.

Behaviour:
- Reset (rst_i=1 at an edge):
  - ps_r=BASLANGIC_PS; tampon (1-entry buffer) invalid; iptal_r=0; bosalt_r=0; atladi_r=1; FSM=ISTE.
  - Combinational outputs while rst_i=1: all 0.
  - Reset mid-transaction abandons any outstanding request; a late response after reset is ignored because FSM is in ISTE.
- Only one request is outstanding at a time. bellek_adres_o={ps_r[31:2],2'b00}.
- FSM states:
  - ISTE: bellek_istek_o=1; address stable until accepted. On bellek_istek_hazir_i go to BEKLE and advance ps_r+=4, unless iptal_r is set.
  - BEKLE: wait for bellek_yanit_gecerli_i.
    - If iptal_r=1: drop the data, clear iptal_r, go to ISTE.
    - Else: load tampon and its PS; go to ISTE if tampon is empty or is being consumed this cycle, else DOLU.
  - DOLU: tampon full. Go to ISTE in the cycle tampon is consumed.
- Issue rule: a new request is issued only when its response can land in a free tampon.
- Queue interface:
  - kuyruk_aktif_o = !coz_durdur_i && (tampon valid || bosalt_r).
  - kuyruk_buyruk_o / ps_o = tampon contents; 0 when invalid.
  - kuyruk_ps_atladi_o = atladi_r && tampon valid.
- Consumption: tampon is consumed when kuyruk_aktif_o=1 && tampon valid && bosalt_r=0. Consumption clears atladi_r.
- Hold: if kuyruk_aktif_o=1 && kuyruk_ps_durdur_i=1, set bosalt_r.
  - The next cycle with kuyruk_aktif_o=1 is a drain cycle: the queue is enabled, the tampon word is NOT consumed, and bosalt_r clears.
  - If the tampon is empty during the drain, kuyruk_aktif_o is still 1 (when coz_durdur_i=0) with kuyruk_buyruk_o=0.
- coz_durdur_i=1: kuyruk_aktif_o=0; tampon and bosalt_r held; fetch continues until tampon is full.
- Redirect (ps_atla_i=1) has priority over all other updates that cycle:
  - ps_r={yeni_ps_i[31:2],2'b00}; tampon invalidated; bosalt_r=0; atladi_r=1.
  - If in ISTE and hazir=0 that cycle: request stays asserted at its old address until accepted, then iptal_r=1 so its response is dropped; the next request uses the new PS.
  - If in ISTE and hazir=1 that cycle: the accepted old request is marked iptal, and ps_r takes the target (no +4).
  - If in BEKLE with no response that cycle: iptal_r=1.
  - If in BEKLE with a response that cycle: the data is dropped and the FSM goes to ISTE with the new PS.
  - If in DOLU: go to ISTE.
  - Back-to-back redirects: last target wins; iptal_r stays a single flag.
- ps_r wraps modulo 2^32 (0xFFFF_FFFC+4=0).

Test Plan:
- Reset, memory hazir=1, 1-cycle response, words 0x00000013 @0x4000_0000 and 0x00100093 @0x4000_0004 → requests at 0x4000_0000 then 0x4000_0004; first word presented with kuyruk_ps_atladi_o=1 and ps_o=0x4000_0000; second word presented with atladi=0.
- Word 0x45014501 presented and the queue asserts kuyruk_ps_durdur_i → next cycle kuyruk_aktif_o=1 with the following word not consumed; that word is re-presented and consumed one cycle later; ps_o sequence 0x…00, 0x…04, 0x…04.
- coz_durdur_i held high for 5 cycles with tampon full → kuyruk_aktif_o=0, bellek_istek_o=0 (FSM in DOLU), outputs stable; resumes on release with no word lost or duplicated.
- ps_atla_i with yeni_ps_i=0x4000_0102 while in BEKLE; stale response 0xDEADBEEF arrives 3 cycles later → 0xDEADBEEF never presented; next request address 0x4000_0100; first delivered word has kuyruk_ps_atladi_o=1.
- ps_atla_i while bellek_istek_o=1 and hazir=0 → address holds until accept; that response is dropped; following request is at the target.
- rst_i asserted while in BEKLE, response arrives during reset → all outputs 0; the first request after reset is at 0x4000_0000.
